// File: rtl/sne_evt_barrier_arbiter_pkg.sv
// Shared event types and constants for the event-stream barrier arbiter.
package sne_evt_barrier_arbiter_pkg;

    // Event op codes carried in the top nibble of every 32-bit event word.
    typedef enum logic [3:0] {
        EVT_SPIKE   = 4'h1,
        EVT_ACCUM   = 4'h2,
        EVT_WIPE    = 4'h3,
        EVT_TIME    = 4'h4,
        EVT_UPDATE  = 4'h5,
        EVT_PKT_END = 4'h6,
        EVT_EOP     = 4'h7,
        EVT_SYNCH   = 4'h8,
        EVT_NEO     = 4'h9
    } operation_t;

    // Synch view of an event word: op code, unused middle bits, barrier id.
    typedef struct packed {
        operation_t  operation;
        logic [19:0] reserved;
        logic [7:0]  barrier_id;
    } barrier_t;

    typedef union packed {
        logic [31:0] raw;
        barrier_t    synch;
    } uevent_t;

    localparam int SNE_ARB_MAX_STREAMS = 16;

    typedef enum logic {ARB_RUN, ARB_COLLECT} evt_arb_state_e;

    // Merged barrier word: only the op code and the id survive the merge.
    function automatic uevent_t sne_arb_synch(input logic [7:0] id);
        uevent_t e;
        e.raw                = '0;
        e.synch.operation    = EVT_SYNCH;
        e.synch.barrier_id   = id;
        return e;
    endfunction

endpackage

// File: rtl/sne_evt_barrier_arbiter_rr.sv
// Combinational N-way round-robin picker; the pointer lives in the parent.
module sne_evt_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index
);

    // Scan from rr_ptr upward (wrapping) and take the first requester.
    always_comb begin
        int   j;
        logic found;
        gnt   = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(rr_ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                index  = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sne_evt_barrier_arbiter.sv
// Merges N event streams round-robin; EVT_SYNCH heads form a barrier that is
// released as one merged synch once every enabled stream has parked on one.
module sne_evt_barrier_arbiter
    import sne_evt_barrier_arbiter_pkg::*;
#(
    parameter int N_STREAMS = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_STREAMS-1:0]       enable_i,
    input  uevent_t [N_STREAMS-1:0]    evt_i,
    input  logic [N_STREAMS-1:0]       evt_valid_i,
    output logic [N_STREAMS-1:0]       evt_ready_o,
    output uevent_t                    evt_o,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic                       barrier_pending_o,
    output logic                       barrier_error_o,
    input  logic                       clear_error_i,
    output logic [CNT_WIDTH-1:0]       barrier_cnt_o
);

    localparam int IW = $clog2(N_STREAMS);

    evt_arb_state_e        state_q, state_d;
    logic [N_STREAMS-1:0]  parked, eligible, gnt;
    logic [IW-1:0]         gnt_idx, rr_ptr_q;
    logic                  all_parked, seen_q, space;
    logic                  do_release, do_grant, id_mismatch;
    logic [7:0]            low_id;

    // Per-stream classification of the head word.
    for (genvar i = 0; i < N_STREAMS; i++) begin : g_stream
        assign parked[i]   = enable_i[i] && evt_valid_i[i] &&
                             (evt_i[i].synch.operation == EVT_SYNCH);
        assign eligible[i] = enable_i[i] && evt_valid_i[i] && !parked[i];
    end

    sne_evt_rr_arbiter #(.N(N_STREAMS), .IW(IW)) u_rr (
        .req    (eligible),
        .rr_ptr (rr_ptr_q),
        .gnt    (gnt),
        .index  (gnt_idx)
    );

    // parked is always a subset of enable, so equality means all are parked.
    assign all_parked = (|enable_i) && (parked == enable_i);
    assign space      = !evt_valid_o || evt_ready_i;
    // The barrier must have been seen complete for a full cycle before release.
    assign do_release = (state_q == ARB_COLLECT) && seen_q && all_parked && space;
    assign do_grant   = !do_release && space && (|eligible);

    // The merged id comes from the lowest-index enabled stream.
    always_comb begin
        low_id = '0;
        for (int i = N_STREAMS - 1; i >= 0; i--)
            if (enable_i[i]) low_id = evt_i[i].synch.barrier_id;
    end

    // Any enabled stream disagreeing with the chosen id flags an error.
    always_comb begin
        id_mismatch = 1'b0;
        for (int i = 0; i < N_STREAMS; i++)
            if (enable_i[i] && evt_i[i].synch.barrier_id != low_id) id_mismatch = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ARB_RUN;
        else         state_q <= state_d;
    end

    // Next state: collecting while anything is parked, back to RUN on release.
    always_comb begin
        state_d = state_q;
        if (do_release)   state_d = ARB_RUN;
        else if (|parked) state_d = ARB_COLLECT;
        else              state_d = ARB_RUN;
    end

    // Head pops: all enabled streams on release, else the round-robin winner.
    always_comb begin
        evt_ready_o = '0;
        if (rst_ni) begin
            if (do_release)    evt_ready_o = enable_i;
            else if (do_grant) evt_ready_o = gnt;
        end
    end

    // Output slot, pointer and barrier bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_o             <= '0;
            evt_valid_o       <= 1'b0;
            rr_ptr_q          <= '0;
            seen_q            <= 1'b0;
            barrier_pending_o <= 1'b0;
            barrier_error_o   <= 1'b0;
            barrier_cnt_o     <= '0;
        end else begin
            seen_q            <= all_parked && !do_release;
            barrier_pending_o <= |parked;
            if (do_release) begin
                evt_o         <= sne_arb_synch(low_id);
                evt_valid_o   <= 1'b1;
                barrier_cnt_o <= barrier_cnt_o + 1'b1;
            end else if (do_grant) begin
                evt_o       <= evt_i[gnt_idx];
                evt_valid_o <= 1'b1;
                rr_ptr_q    <= (gnt_idx == IW'(N_STREAMS - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (evt_ready_i) begin
                evt_valid_o <= 1'b0;
            end
            if (clear_error_i)                  barrier_error_o <= 1'b0;
            else if (do_release && id_mismatch) barrier_error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sne_evt_barrier_arbiter.sv
// Self-checking bench: table vectors, directed barrier sequences, random run.
module tb_sne_evt_barrier_arbiter;
    import sne_evt_barrier_arbiter_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [3:0]    enable_i;
    uevent_t [3:0] evt_i;
    logic [3:0]    evt_valid_i;
    logic [3:0]    evt_ready_o;
    uevent_t       evt_o;
    logic          evt_valid_o;
    logic          evt_ready_i;
    logic          barrier_pending_o;
    logic          barrier_error_o;
    logic          clear_error_i;
    logic [2:0]    barrier_cnt_o;

    sne_evt_barrier_arbiter #(.N_STREAMS(4), .CNT_WIDTH(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .evt_i(evt_i),
        .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o), .evt_o(evt_o),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
        .barrier_pending_o(barrier_pending_o), .barrier_error_o(barrier_error_o),
        .clear_error_i(clear_error_i), .barrier_cnt_o(barrier_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] en, vld, syn, exp_rdy;
        logic       exp_v;
        int         exp_s;
    } vec_t;

    logic [31:0] q     [4][$];
    logic [31:0] exp_q [4][$];
    logic [31:0] out_q[$];
    int          out_cyc[$];
    logic [3:0]  pop_log[$];
    logic [3:0]  vmask;
    logic        stall_prev, pend_seen;
    logic [31:0] w_prev;
    int          cyc, n_chk, n_fail;
    operation_t  ops[8];
    vec_t        tbl[8];

    function automatic logic [31:0] ev(input operation_t op, input int s, input int seq);
        return {op, 4'(s), 8'h00, 16'(seq)};
    endfunction

    // Input synch words carry junk in the middle bits; the merge must drop it.
    function automatic logic [31:0] sy(input int s, input int id);
        return {EVT_SYNCH, 4'(s), 8'hA5, 8'h00, 8'(id)};
    endfunction

    function automatic logic [31:0] merged(input int id);
        return {EVT_SYNCH, 20'h0, 8'(id)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            evt_valid_i[i] = (q[i].size() > 0) && vmask[i];
            evt_i[i].raw   = (q[i].size() > 0) ? q[i][0] : 32'h0;
        end
    endtask

    // One clock: drive heads, sample, let the edge happen, log transfers.
    task automatic cycle();
        logic [3:0]  r;
        logic        v;
        logic [31:0] w;
        drive();
        #1;
        r = evt_ready_o; v = evt_valid_o; w = evt_o.raw;
        if (stall_prev) begin
            chk("stall_valid", 32'(v), 1);
            chk("stall_word", w, w_prev);
        end
        stall_prev = v && !evt_ready_i;
        w_prev     = w;
        for (int i = 0; i < 4; i++)
            if (r[i]) chk("pop_needs_valid", 32'(evt_valid_i[i]), 1);
        pend_seen = pend_seen | barrier_pending_o;
        @(posedge clk_i);
        #1;
        if (v && evt_ready_i) begin
            out_q.push_back(w);
            out_cyc.push_back(cyc);
        end
        pop_log.push_back(r);
        for (int i = 0; i < 4; i++)
            if (r[i] && q[i].size() > 0) void'(q[i].pop_front());
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_until(input string nm, input int target, input int budget);
        int k;
        k = 0;
        while (out_q.size() < target && k < budget) begin
            cycle();
            k++;
        end
        chk(nm, out_q.size(), target);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        out_q.delete(); out_cyc.delete(); pop_log.delete();
        vmask = 4'hF; enable_i = 4'hF; evt_ready_i = 1'b1; clear_error_i = 1'b0;
        stall_prev = 1'b0; pend_seen = 1'b0;
        drive();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc    = 0;
    endtask

    // Random run checked against per-stream expected queues.
    task automatic check_model();
        for (int k = 0; k < out_q.size(); k++) begin
            logic [31:0] w;
            logic        heads_ok;
            int          s;
            w = out_q[k];
            if (w[31:28] == EVT_SYNCH) begin
                heads_ok = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (exp_q[i].size() == 0 || exp_q[i][0][31:28] != EVT_SYNCH) heads_ok = 1'b0;
                chk("rnd_synch_all_heads", 32'(heads_ok), 1);
                if (exp_q[0].size() > 0) chk("rnd_synch_word", w, merged(int'(exp_q[0][0][7:0])));
                for (int i = 0; i < 4; i++)
                    if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
            end else begin
                s = int'(w[27:24]);
                if (s < 4 && exp_q[s].size() > 0) begin
                    chk("rnd_evt_order", w, exp_q[s][0]);
                    void'(exp_q[s].pop_front());
                end else begin
                    n_chk++; n_fail++;
                    $display("FAIL rnd_evt_unexpected: got %0h expected none", w);
                end
            end
        end
        for (int i = 0; i < 4; i++) chk("rnd_all_delivered", exp_q[i].size(), 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        ops = '{EVT_SPIKE, EVT_ACCUM, EVT_WIPE, EVT_TIME, EVT_UPDATE, EVT_PKT_END, EVT_EOP, EVT_NEO};
        //           en     vld    syn    exp_rdy exp_v exp_s
        tbl[0] = '{4'hF, 4'hF, 4'h0, 4'h1, 1'b1, 0};
        tbl[1] = '{4'hF, 4'hA, 4'h0, 4'h2, 1'b1, 1};
        tbl[2] = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 0};
        tbl[3] = '{4'hF, 4'hF, 4'h1, 4'h2, 1'b1, 1};
        tbl[4] = '{4'h7, 4'hF, 4'h7, 4'h0, 1'b0, 0};
        tbl[5] = '{4'hE, 4'hF, 4'h0, 4'h2, 1'b1, 1};
        tbl[6] = '{4'hF, 4'h8, 4'h0, 4'h8, 1'b1, 3};
        tbl[7] = '{4'hB, 4'hF, 4'h8, 4'h1, 1'b1, 0};

        // Reset state, with valid heads presented while reset is held.
        rst_ni = 1'b0; vmask = 4'hF; enable_i = 4'hF; evt_ready_i = 1'b1; clear_error_i = 1'b0;
        for (int i = 0; i < 4; i++) q[i].push_back(ev(EVT_SPIKE, i, 0));
        drive();
        #1;
        chk("rst_ready", 32'(evt_ready_o), 0);
        chk("rst_valid", 32'(evt_valid_o), 0);
        chk("rst_evt", evt_o.raw, 0);
        chk("rst_pending", 32'(barrier_pending_o), 0);
        chk("rst_error", 32'(barrier_error_o), 0);
        chk("rst_cnt", 32'(barrier_cnt_o), 0);
        @(posedge clk_i); #1;
        chk("rst_ready_edge", 32'(evt_ready_o), 0);

        // Table vectors: one cycle from reset, grant and loaded word.
        for (int k = 0; k < 8; k++) begin
            do_reset();
            enable_i = tbl[k].en;
            vmask    = tbl[k].vld;
            for (int i = 0; i < 4; i++)
                q[i].push_back(tbl[k].syn[i] ? sy(i, 3) : ev(ops[(k + i) % 8], i, k));
            cycle();
            chk("tbl_ready", 32'(pop_log[0]), 32'(tbl[k].exp_rdy));
            chk("tbl_valid_o", 32'(evt_valid_o), 32'(tbl[k].exp_v));
            if (tbl[k].exp_v)
                chk("tbl_evt_o", evt_o.raw, ev(ops[(k + tbl[k].exp_s) % 8], tbl[k].exp_s, k));
        end

        // Round robin: 4 x 3 spikes, one per cycle after one cycle of latency.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) q[i].push_back(ev(EVT_SPIKE, i, k));
        run_until("rr_count", 12, 40);
        for (int k = 0; k < out_q.size() && k < 12; k++) begin
            chk("rr_order", out_q[k], ev(EVT_SPIKE, k % 4, k / 4));
            chk("rr_cycle", 32'(out_cyc[k]), 32'(k + 1));
        end

        // Barrier: s0/s2 park at cycle 2, s1/s3 send two spikes then park.
        do_reset();
        q[0].push_back(sy(0, 5)); q[2].push_back(sy(2, 5));
        for (int i = 1; i < 4; i += 2) begin
            q[i].push_back(ev(EVT_SPIKE, i, 0));
            q[i].push_back(ev(EVT_SPIKE, i, 1));
            q[i].push_back(sy(i, 5));
        end
        vmask = 4'hA;
        run(2);
        vmask = 4'hF;
        run_until("bar_count", 5, 30);
        if (out_q.size() == 5) begin
            chk("bar_spk0", out_q[0], ev(EVT_SPIKE, 1, 0));
            chk("bar_spk1", out_q[1], ev(EVT_SPIKE, 3, 0));
            chk("bar_spk2", out_q[2], ev(EVT_SPIKE, 1, 1));
            chk("bar_spk3", out_q[3], ev(EVT_SPIKE, 3, 1));
            chk("bar_synch", out_q[4], merged(5));
            chk("bar_release_pop", 32'(pop_log[5]), 4'hF);
        end
        chk("bar_cnt", 32'(barrier_cnt_o), 1);
        chk("bar_error", 32'(barrier_error_o), 0);
        chk("bar_pending_seen", 32'(pend_seen), 1);

        // Mismatched ids: one synch with the s0 id, sticky error until cleared.
        do_reset();
        q[0].push_back(sy(0, 5)); q[1].push_back(sy(1, 5));
        q[2].push_back(sy(2, 6)); q[3].push_back(sy(3, 5));
        run_until("mis_count", 1, 10);
        if (out_q.size() == 1) chk("mis_synch", out_q[0], merged(5));
        chk("mis_release_pop", 32'(pop_log[1]), 4'hF);
        run(3);
        chk("mis_error_sticky", 32'(barrier_error_o), 1);
        chk("mis_single_synch", out_q.size(), 1);
        clear_error_i = 1'b1;
        cycle();
        clear_error_i = 1'b0;
        chk("mis_error_cleared", 32'(barrier_error_o), 0);
        for (int i = 0; i < 4; i++) q[i].push_back(sy(i, (i == 1) ? 9 : 4));
        clear_error_i = 1'b1;
        run_until("mis2_count", 2, 10);
        run(1);
        clear_error_i = 1'b0;
        chk("mis2_clear_wins", 32'(barrier_error_o), 0);
        chk("mis2_cnt", 32'(barrier_cnt_o), 2);
        if (out_q.size() == 2) chk("mis2_synch", out_q[1], merged(4));

        // Backpressure: ten cycles stalled, then order resumes from s1.
        do_reset();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) q[i].push_back(ev(EVT_SPIKE, i, k));
        evt_ready_i = 1'b0;
        run(10);
        chk("bp_first_pop", 32'(pop_log[0]), 4'h1);
        for (int k = 1; k < 10; k++) chk("bp_no_pop", 32'(pop_log[k]), 0);
        chk("bp_held_valid", 32'(evt_valid_o), 1);
        chk("bp_held_word", evt_o.raw, ev(EVT_SPIKE, 0, 0));
        evt_ready_i = 1'b1;
        run_until("bp_count", 9, 40);
        for (int k = 0; k < out_q.size() && k < 9; k++)
            chk("bp_order", out_q[k], ev(EVT_SPIKE, k % 3, k / 3));

        // Disable: s0-s2 parked, s3 streams spikes until it is disabled.
        do_reset();
        for (int i = 0; i < 3; i++) q[i].push_back(sy(i, 7));
        for (int k = 0; k < 4; k++) q[3].push_back(ev(EVT_SPIKE, 3, k));
        run(2);
        enable_i = 4'h7;
        run(6);
        chk("dis_s3_pops", 32'(pop_log[0] & pop_log[1]), 4'h8);
        chk("dis_wait", 32'(pop_log[2]), 0);
        chk("dis_release", 32'(pop_log[3]), 4'h7);
        for (int k = 4; k < 8; k++) chk("dis_s3_held", 32'(pop_log[k][3]), 0);
        chk("dis_out_count", out_q.size(), 3);
        if (out_q.size() == 3) chk("dis_synch", out_q[2], merged(7));
        enable_i = 4'hF;
        run_until("dis_resume_count", 5, 20);
        if (out_q.size() == 5) chk("dis_resume", out_q[4], ev(EVT_SPIKE, 3, 3));
        chk("dis_cnt", 32'(barrier_cnt_o), 1);

        // Reset in the middle of a collect phase.
        do_reset();
        q[0].push_back(ev(EVT_SPIKE, 0, 0)); q[0].push_back(ev(EVT_SPIKE, 0, 1));
        q[1].push_back(sy(1, 2)); q[2].push_back(sy(2, 2));
        q[3].push_back(ev(EVT_SPIKE, 3, 0)); q[3].push_back(ev(EVT_SPIKE, 3, 1));
        cycle();
        chk("mid_pending", 32'(barrier_pending_o), 1);
        chk("mid_valid", 32'(evt_valid_o), 1);
        rst_ni = 1'b0;
        drive();
        #1;
        chk("mid_rst_valid", 32'(evt_valid_o), 0);
        chk("mid_rst_evt", evt_o.raw, 0);
        chk("mid_rst_pending", 32'(barrier_pending_o), 0);
        chk("mid_rst_ready", 32'(evt_ready_o), 0);
        @(posedge clk_i); #1;
        chk("mid_rst_ready_edge", 32'(evt_ready_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        stall_prev = 1'b0;
        cycle();
        chk("mid_next_grant_s0", 32'(pop_log[pop_log.size() - 1]), 4'h1);
        chk("mid_cnt", 32'(barrier_cnt_o), 0);

        // Random traffic: 10 barriers per stream, random valid gaps and stalls.
        do_reset();
        begin
            int nseg, seq, guard;
            logic busy;
            nseg = 10;
            for (int i = 0; i < 4; i++) begin
                exp_q[i].delete();
                seq = 0;
                for (int j = 0; j < nseg; j++) begin
                    int n;
                    n = int'($urandom_range(0, 3));
                    for (int e = 0; e < n; e++) begin
                        q[i].push_back(ev(ops[$urandom_range(0, 7)], i, seq));
                        seq++;
                    end
                    q[i].push_back(sy(i, j));
                end
                exp_q[i] = q[i];
            end
            guard = 0;
            busy  = 1'b1;
            while (busy && guard < 3000) begin
                vmask       = 4'($urandom) | 4'($urandom);
                evt_ready_i = ($urandom_range(0, 3) != 0);
                cycle();
                guard++;
                busy = evt_valid_o;
                for (int i = 0; i < 4; i++) if (q[i].size() > 0) busy = 1'b1;
            end
            chk("rnd_drained", 32'(busy), 0);
            check_model();
            chk("rnd_cnt_wrap", 32'(barrier_cnt_o), 32'(nseg % 8));
            chk("rnd_error", 32'(barrier_error_o), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sne_evt_barrier_arbiter.md
# sne_evt_barrier_arbiter

Merges N independent event streams (one per engine slice or input port) into the single event stream that feeds the neuron-group datapath. Ordinary events (spike, accumulate, wipe, time, update, pkt_end, EOP) are granted round-robin. EVT_SYNCH events act as a barrier: the block holds each stream at its synch word until every enabled stream has reached one, then emits a single merged EVT_SYNCH downstream.

## Interface
- N_STREAMS, default 4: number of input streams, ≥2.
- CNT_WIDTH, default 16: width of the barrier counter.

- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- enable_i  in  N_STREAMS  per-stream enable. A disabled stream is never granted and is excluded from barriers.
- evt_i  in  N_STREAMS×32  head event per stream, as uevent_t.
- evt_valid_i  in  N_STREAMS  head valid.
- evt_ready_o  out  N_STREAMS  head pop.
- evt_o  out  32  merged event (uevent_t), registered.
- evt_valid_o  out  1  output valid.
- evt_ready_i  in  1  downstream ready.
- barrier_pending_o  out  1  at least one enabled stream is parked at EVT_SYNCH.
- barrier_error_o  out  1  sticky flag: a barrier merged mismatched barrier_id values.
- clear_error_i  in  1  clears barrier_error_o.
- barrier_cnt_o  out  CNT_WIDTH  count of completed barriers; wraps.

## Operation
- Handshake: a transfer occurs when valid and ready are both high on the same rising edge. evt_valid_o stays high and evt_o stays stable until accepted.
- Output slot: a single register. space = !evt_valid_o || evt_ready_i.
- Parked: stream i with enable_i[i] && evt_valid_i[i] && evt_i[i].synch.operation==EVT_SYNCH.
- Eligible: enabled, valid, and not parked.
- States:
  - RUN: no enabled stream is parked. Round-robin grant among eligible streams, starting at rr_ptr. If space, assert evt_ready_o[g], load evt_o←evt_i[g], and set rr_ptr←g+1 (mod N).
  - COLLECT: at least one enabled stream is parked. Eligible streams keep being granted as in RUN. Parked streams see evt_ready_o=0.
- Release: when every enabled stream is parked and space is available, in the same cycle:
  - pulse evt_ready_o high for all enabled streams;
  - load evt_o with operation EVT_SYNCH and barrier_id from the lowest-index enabled stream;
  - increment barrier_cnt_o;
  - go to RUN. rr_ptr is unchanged.
- Release takes priority over normal grants; during the release cycle no other grant happens.
- If any enabled barrier_id differs from the chosen one, set barrier_error_o; the release still happens.
- Disabling the last non-parked stream completes the barrier, and release follows on the next eligible cycle.
- enable_i == 0 (all streams disabled): nothing is granted, and the block stays in RUN.
- NEO and any other op code are forwarded unchanged.
- evt_ready_o may depend combinationally on evt_valid_i, evt_i, and evt_ready_i. evt_valid_o and evt_o must not depend combinationally on any input.
- clear_error_i has priority over setting barrier_error_o in the same cycle.

## Timing
- Reset values: evt_valid_o=0, evt_o=0, barrier_pending_o=0, barrier_error_o=0, barrier_cnt_o=0, rr_ptr=0, state RUN. evt_ready_o=0 while rst_ni is low.
- Latency from input transfer to evt_valid_o is one cycle.
- With evt_ready_i held at 1, throughput is one event per cycle.
- Release happens one cycle after the last stream parks (the cycle where its head is first seen parked) if space is available. The merged synch appears on evt_o the following cycle.
- barrier_pending_o is registered and reflects the parked set from the previous cycle.
- barrier_cnt_o wraps from 2^CNT_WIDTH−1 to 0.
- Asserting rst_ni low mid-barrier or mid-stall drops the output word and clears all state. Input streams are never popped during reset.

## Structure
- Shared package gets:
  - operation_t and barrier_t, reused as-is;
  - new localparam SNE_ARB_MAX_STREAMS = 16;
  - typedef evt_arb_state_e {ARB_RUN, ARB_COLLECT}.
- Sub-module sne_evt_rr_arbiter: parameterised N-way round-robin arbiter.
  - Inputs: req, rr_ptr.
  - Outputs: one-hot gnt and index.
  - Purely combinational. Pointer state is kept in the parent.
- Target size of the parent: about 200 lines.

## Test plan
- Round-robin: 4 streams each with 3 EVT_SPIKE events, ready held at 1 → output order s0,s1,s2,s3,s0,… with 12 events and one per cycle after a 1-cycle latency.
- Barrier: s0 and s2 present EVT_SYNCH id 5 at cycle 2; s1 and s3 send 2 spikes, then synch id 5.
  - Required: all 4 spikes out before the barrier; exactly one EVT_SYNCH id 5 out; all 4 heads popped in the same cycle; barrier_cnt_o=1.
- Mismatch: ids 5,5,6,5 → single synch id 5, barrier_error_o=1 until clear_error_i is pulsed.
- Backpressure: evt_ready_i=0 for 10 cycles with 3 valid streams → evt_o stable, no pops, nothing lost; after release, order continues from rr_ptr.
- Disable: s3 has no synch; drop enable_i[3] while s0–s2 are parked → release on the next cycle; s3 events are never granted while disabled.
- Reset mid-COLLECT: rst_ni low for 1 cycle → all outputs at reset values, barrier_cnt_o=0, next grant goes to s0.
